// File: rtl/pwm_gen.sv
// pwm_gen: multi-channel signed-effort PWM generator
// Shared period counter, boundary-latched duty, per-channel watchdog.
module pwm_gen #(
    parameter int N_CHN   = 2,
    parameter int CHN_W   = 1,
    parameter int DATA_W  = 16,
    parameter int PERIOD  = 1000,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              u_valid_i,
    input  logic [CHN_W-1:0]  u_chn_i,
    input  logic [DATA_W-1:0] u_data_i,
    output logic [N_CHN-1:0]  pwm_o,
    output logic [N_CHN-1:0]  dir_o,
    output logic [N_CHN-1:0]  timeout_o,
    output logic              sample_o
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [DATA_W-1:0] PMAX  = DATA_W'(PERIOD);
    localparam logic [DATA_W-1:0] PLAST = DATA_W'(PERIOD - 1);
    localparam logic [DATA_W-1:0] MINV  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAXV  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [WD_W-1:0]   WDMAX = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]   WDPRE = WD_W'(TIMEOUT - 1);

    logic [DATA_W-1:0] cnt;
    logic              bnd;
    logic              sgn;
    logic [DATA_W-1:0] absv;
    logic [DATA_W-1:0] mag;
    logic [N_CHN-1:0]  acc;
    logic [N_CHN-1:0]  pend_dir;
    logic [DATA_W-1:0] pend_mag [N_CHN];
    logic [DATA_W-1:0] duty     [N_CHN];
    logic [WD_W-1:0]   wd       [N_CHN];

    assign bnd = (cnt == PLAST);
    assign sgn = u_data_i[DATA_W-1];

    // Magnitude of the incoming word, most-negative saturated, clamped to PERIOD
    always_comb begin
        absv = u_data_i;
        if (sgn) begin
            absv = (u_data_i == MINV) ? MAXV : -u_data_i;
        end
        mag = (absv > PMAX) ? PMAX : absv;
    end

    // Per-channel accept strobe; out-of-range indices match no channel
    always_comb begin
        acc = '0;
        for (int c = 0; c < N_CHN; c++) begin
            acc[c] = u_valid_i && (32'(u_chn_i) == c);
        end
    end

    // Shared period counter and end-of-period sample pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            sample_o <= 1'b0;
        end else begin
            cnt      <= bnd ? '0 : cnt + DATA_W'(1);
            sample_o <= bnd;
        end
    end

    // Pending capture, watchdog, and boundary load of active duty/dir
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < N_CHN; c++) begin
                pend_mag[c] <= '0;
                duty[c]     <= '0;
                wd[c]       <= '0;
            end
            pend_dir  <= '0;
            dir_o     <= '0;
            timeout_o <= '0;
        end else begin
            for (int c = 0; c < N_CHN; c++) begin
                if (acc[c]) begin
                    pend_mag[c]  <= mag;
                    pend_dir[c]  <= sgn;
                    wd[c]        <= '0;
                    timeout_o[c] <= 1'b0;
                end else if (bnd && wd[c] == WDPRE) begin
                    pend_mag[c]  <= '0;
                    pend_dir[c]  <= 1'b0;
                    wd[c]        <= WDMAX;
                    timeout_o[c] <= 1'b1;
                end else if (bnd && wd[c] != WDMAX) begin
                    wd[c] <= wd[c] + WD_W'(1);
                end
                if (bnd) begin
                    duty[c]  <= acc[c] ? mag : pend_mag[c];
                    dir_o[c] <= acc[c] ? sgn : pend_dir[c];
                end
            end
        end
    end

    // PWM compare, decoded from registered counter and duty only
    always_comb begin
        pwm_o = '0;
        for (int c = 0; c < N_CHN; c++) begin
            pwm_o[c] = (cnt < duty[c]);
        end
    end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 The block SHALL have parameter N_CHN, default 2: number of motor channels.
REQ-002 The block SHALL have parameter CHN_W, default 1: width of the channel index.
REQ-003 The block SHALL have parameter DATA_W, default 16: width of the signed control word.
REQ-004 The block SHALL have parameter PERIOD, default 1000: PWM period in clk cycles, with 2 <= PERIOD < 2^(DATA_W-1).
REQ-005 The block SHALL have parameter TIMEOUT, default 8: number of PWM periods without an update before a channel is disabled.
REQ-006 The block SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-007 The block SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port u_valid_i, input, 1 bit: control-word strobe from the PID stage; there is no backpressure.
REQ-009 The block SHALL have port u_chn_i, input, CHN_W bits: target channel of the control word.
REQ-010 The block SHALL have port u_data_i, input, DATA_W bits: signed two's-complement control effort.
REQ-011 The block SHALL have port pwm_o, output, N_CHN bits: PWM drive, one bit per channel.
REQ-012 The block SHALL have port dir_o, output, N_CHN bits: direction, 1 = reverse (negative effort).
REQ-013 The block SHALL have port timeout_o, output, N_CHN bits: watchdog-expired flag per channel.
REQ-014 The block SHALL have port sample_o, output, 1 bit: one-cycle pulse marking the end of each PWM period, used to trigger the next PID computation.

Function
REQ-015 A shared period counter SHALL count 0..PERIOD-1, increment every cycle, and wrap to 0. The cycle in which cnt==PERIOD-1 is the boundary cycle.
REQ-016 sample_o SHALL be registered and SHALL be 1 for exactly the one cycle following each boundary cycle.
REQ-017 In a cycle with u_valid_i=1 and u_chn_i<N_CHN, the pending registers of that channel SHALL capture the update at that clock edge:
- magnitude = |u_data_i|, with -2^(DATA_W-1) mapping to 2^(DATA_W-1)-1;
- magnitude clamped to PERIOD;
- direction = sign bit of u_data_i.
REQ-018 When u_valid_i=1 and u_chn_i>=N_CHN, the update SHALL be ignored with no state change.
REQ-019 Several updates to the same channel within one period SHALL be resolved last-write-wins.
REQ-020 On the edge ending a boundary cycle, each channel's active duty and dir_o SHALL load from its pending registers. If a valid update to that channel occurs in the same boundary cycle, the new value SHALL be loaded directly (bypass).
REQ-021 Active duty and dir_o SHALL NOT change at any other time; duty changes are glitch-free and take effect at period start.
REQ-022 pwm_o[c] SHALL equal (cnt < duty_act[c]), decoded only from registers, with no combinational path from any input:
- duty 0 gives constant low;
- duty PERIOD gives constant high.
REQ-023 Each channel SHALL have a watchdog counter, cleared by any accepted update to that channel and incremented at each boundary cycle, saturating at TIMEOUT.
REQ-024 When the watchdog reaches TIMEOUT, the channel's pending magnitude SHALL be forced to 0 and pending dir to 0, and timeout_o[c] SHALL be set. The forced zero becomes active at the next boundary, per REQ-020.
REQ-025 timeout_o[c] SHALL clear on the next accepted update to that channel.
REQ-026 If an accepted update and a watchdog expiry for a channel coincide in the same cycle, the update SHALL win: values are captured, the watchdog is cleared, and timeout_o stays 0.
REQ-027 All channels SHALL share one counter and be mutually phase-aligned.

Reset
REQ-028 While rstn=0, the block SHALL immediately (asynchronously) force:
- cnt=0;
- pending and active duty and dir = 0;
- watchdog counters = 0;
- pwm_o=0, dir_o=0, timeout_o=0, sample_o=0.
REQ-029 After rstn rises, counting SHALL start from 0 on the first clock edge, and the first sample_o pulse SHALL occur PERIOD cycles later.
REQ-030 Reset asserted mid-period SHALL discard all pending updates; no partial period completes.

Verification (N_CHN=2, DATA_W=16, PERIOD=100, TIMEOUT=4)
REQ-031 The bench SHALL check: update ch0=+25 mid-period -> from the next period start, pwm_o[0] is high for 25 cycles and low for 75, and dir_o[0]=0; the current period is unchanged.
REQ-032 The bench SHALL check: ch1=-300 -> duty clamps to 100, pwm_o[1] is constantly high, and dir_o[1]=1; then ch1=-32768 -> still 100, with dir_o[1]=1.
REQ-033 The bench SHALL check: ch0 updates 10 then 60 in the same period, with the second write in the boundary cycle -> the next period duty is 60 (bypass, last-write-wins).
REQ-034 The bench SHALL check: no ch0 updates for 4 periods after +50 -> timeout_o[0]=1, and pwm_o[0]=0 from the following period. Then ch0=+20 -> timeout_o[0]=0 immediately, and duty is 20 from the next period.
REQ-035 The bench SHALL check: u_chn_i=1 with value 0, then an update with u_chn_i out of range (use CHN_W=2 in this test) -> the out-of-range update causes no change on any output.
REQ-036 The bench SHALL check: rstn pulsed low at cnt=40 with ch0 duty 70 -> all outputs are 0 at once, and the first sample_o pulse occurs 100 cycles after release.
